fp_align_add: RTL and testbench

FP_ALIGN_ADD -- requirements
Module: fp_align_add

---
 rtl/fp_align_add_pkg.sv | 28 ++
 rtl/fp_unpack.sv | 23 ++
 rtl/fp_align_add.sv | 184 ++++++++++++++++++
 tb/tb_fp_align_add.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_align_add_pkg.sv
// Shared single-precision definitions for the alignment/add stage:
// field widths, the sign/exponent/fraction view and the control states.
package fp_align_add_pkg;

  localparam int EXP_MAX   = 255;
  localparam int EXP_W     = $clog2(EXP_MAX + 1);
  localparam int MANT_W    = 24;
  localparam int FRAC_W    = MANT_W - 1;
  localparam int SHIFT_CAP = 26;
  localparam int CNT_W     = $clog2(SHIFT_CAP + 1);
  // Mantissa plus guard, round and sticky positions.
  localparam int FIELD_W   = MANT_W + 3;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_SHIFT,
    ST_ADD,
    ST_DONE
  } state_t;

endpackage

// File: rtl/fp_unpack.sv
// Splits one single-precision operand into sign, hidden-bit mantissa and
// effective exponent; denormals take exponent 1 with a zero hidden bit.
module fp_unpack
  import fp_align_add_pkg::*;
(
  input  logic [31:0]             op,
  output logic                    sign,
  output logic [EXP_W-1:0]        eff_exp,
  output logic [MANT_W-1:0]       mant,
  output logic [EXP_W+FRAC_W-1:0] mag
);

  fp32_t f;
  logic  hidden;

  assign f       = op;
  assign hidden  = (f.exp != '0);
  assign sign    = f.sign;
  assign mant    = {hidden, f.frac};
  assign eff_exp = hidden ? f.exp : EXP_W'(1);
  assign mag     = {f.exp, f.frac};

endmodule

// File: rtl/fp_align_add.sv
// Multi-cycle FP add front end: orders two operands by magnitude, shifts the
// smaller one right one bit per cycle with sticky collection, then adds/subtracts.
module fp_align_add
  import fp_align_add_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] alignedResult,
  output logic        carryOut,
  output logic [7:0]  exponentOut,
  output logic        alignedSign,
  output logic        guardBit,
  output logic        roundBit,
  output logic        stickyBit
);

  localparam logic [EXP_W-1:0] SHIFT_CAP_E = EXP_W'(SHIFT_CAP);

  state_t state_q, state_d;

  logic [31:0]        op_a_q, op_a_d, op_b_q, op_b_d;
  logic               sign_l_q, sign_l_d;
  logic [EXP_W-1:0]   exp_l_q, exp_l_d;
  logic [MANT_W-1:0]  mant_l_q, mant_l_d;
  logic [FIELD_W-1:0] s_field_q, s_field_d;
  logic               sub_q, sub_d;
  logic [CNT_W-1:0]   n_q, n_d, cnt_q, cnt_d;
  logic [MANT_W-1:0]  result_q, result_d;
  logic               carry_q, carry_d;
  logic [EXP_W-1:0]   exp_out_q, exp_out_d;
  logic               sign_out_q, sign_out_d;
  logic [2:0]         grs_q, grs_d;

  logic                    sign_a, sign_b;
  logic [EXP_W-1:0]        eexp_a, eexp_b;
  logic [MANT_W-1:0]       mant_a, mant_b;
  logic [EXP_W+FRAC_W-1:0] mag_a, mag_b;

  logic               a_ge_b;
  logic [EXP_W-1:0]   exp_big, exp_small, diff, diff_capped;
  logic [MANT_W-1:0]  mant_small;
  logic [FIELD_W:0]   wide_l, wide_s, sum;

  fp_unpack u_unpack_a (
    .op      (op_a_q),
    .sign    (sign_a),
    .eff_exp (eexp_a),
    .mant    (mant_a),
    .mag     (mag_a)
  );

  fp_unpack u_unpack_b (
    .op      (op_b_q),
    .sign    (sign_b),
    .eff_exp (eexp_b),
    .mant    (mant_b),
    .mag     (mag_b)
  );

  assign in_ready      = (state_q == ST_IDLE);
  assign out_valid     = (state_q == ST_DONE);
  assign alignedResult = result_q;
  assign carryOut      = carry_q;
  assign exponentOut   = exp_out_q;
  assign alignedSign   = sign_out_q;
  assign guardBit      = grs_q[2];
  assign roundBit      = grs_q[1];
  assign stickyBit     = grs_q[0];

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    sign_l_d   = sign_l_q;
    exp_l_d    = exp_l_q;
    mant_l_d   = mant_l_q;
    s_field_d  = s_field_q;
    sub_d      = sub_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    carry_d    = carry_q;
    exp_out_d  = exp_out_q;
    sign_out_d = sign_out_q;
    grs_d      = grs_q;

    // Ties keep operand A as the larger, which only matters for the sign.
    a_ge_b      = (mag_a >= mag_b);
    exp_big     = a_ge_b ? eexp_a : eexp_b;
    exp_small   = a_ge_b ? eexp_b : eexp_a;
    mant_small  = a_ge_b ? mant_b : mant_a;
    diff        = exp_big - exp_small;
    diff_capped = (diff > SHIFT_CAP_E) ? SHIFT_CAP_E : diff;

    wide_l = {1'b0, mant_l_q, 3'b000};
    wide_s = {1'b0, s_field_q};
    sum    = sub_q ? (wide_l - wide_s) : (wide_l + wide_s);

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_a_d  = op_a;
          op_b_d  = op_b;
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        sign_l_d  = a_ge_b ? sign_a : sign_b;
        exp_l_d   = exp_big;
        mant_l_d  = a_ge_b ? mant_a : mant_b;
        s_field_d = {mant_small, 3'b000};
        sub_d     = sign_a ^ sign_b;
        n_d       = CNT_W'(diff_capped);
        cnt_d     = '0;
        state_d   = (n_d != '0) ? ST_SHIFT : ST_ADD;
      end
      ST_SHIFT: begin
        // Bits falling off the round position are OR-ed into sticky.
        s_field_d = {1'b0, s_field_q[FIELD_W-1:2], s_field_q[1] | s_field_q[0]};
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_d == n_q) begin
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        result_d   = sum[FIELD_W-1:3];
        carry_d    = sum[FIELD_W];
        grs_d      = sum[2:0];
        exp_out_d  = exp_l_q;
        sign_out_d = (sum == '0) ? 1'b0 : sign_l_q;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      sign_l_q   <= 1'b0;
      exp_l_q    <= '0;
      mant_l_q   <= '0;
      s_field_q  <= '0;
      sub_q      <= 1'b0;
      n_q        <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      exp_out_q  <= '0;
      sign_out_q <= 1'b0;
      grs_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      sign_l_q   <= sign_l_d;
      exp_l_q    <= exp_l_d;
      mant_l_q   <= mant_l_d;
      s_field_q  <= s_field_d;
      sub_q      <= sub_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      exp_out_q  <= exp_out_d;
      sign_out_q <= sign_out_d;
      grs_q      <= grs_d;
    end
  end

endmodule

// File: tb/tb_fp_align_add.sv
// Directed bench for fp_align_add: hand-computed alignment/add vectors,
// latency, backpressure and asynchronous reset behaviour.
module tb_fp_align_add;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] alignedResult;
  logic        carryOut;
  logic [7:0]  exponentOut;
  logic        alignedSign;
  logic        guardBit;
  logic        roundBit;
  logic        stickyBit;

  int compared   = 0;
  int mismatched = 0;
  int lat;
  int seen;

  always #5 clk = ~clk;

  fp_align_add dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .op_a          (op_a),
    .op_b          (op_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alignedResult (alignedResult),
    .carryOut      (carryOut),
    .exponentOut   (exponentOut),
    .alignedSign   (alignedSign),
    .guardBit      (guardBit),
    .roundBit      (roundBit),
    .stickyBit     (stickyBit)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Latency counts the accepting edge as the first edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input int expLat, input string tag);
    @(negedge clk);
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
  endtask

  task automatic checkResult(input string tag, input logic [23:0] res, input logic carry,
                             input logic [7:0] expo, input logic sign, input logic [2:0] grs);
    checkOutput({tag, " result"}, 32'(alignedResult), 32'(res));
    checkOutput({tag, " carry"}, 32'(carryOut), 32'(carry));
    checkOutput({tag, " exponent"}, 32'(exponentOut), 32'(expo));
    checkOutput({tag, " sign"}, 32'(alignedSign), 32'(sign));
    checkOutput({tag, " grs"}, 32'({guardBit, roundBit, stickyBit}), 32'(grs));
  endtask

  task automatic drainOutput(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checkOutput({tag, " idle in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    #12;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkResult("reset", 24'h0, 1'b0, 8'd0, 1'b0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    // 1.0 + 1.0: the sum overflows entirely into the carry bit.
    applyStimulus(32'h3F800000, 32'h3F800000, 3, "one_plus_one");
    checkResult("one_plus_one", 24'h000000, 1'b1, 8'd127, 1'b0, 3'b000);
    drainOutput("one_plus_one");

    applyStimulus(32'h3F800000, 32'h33800000, 27, "smallest_term");
    checkResult("smallest_term", 24'h800000, 1'b0, 8'd127, 1'b0, 3'b100);
    drainOutput("smallest_term");

    applyStimulus(32'h3F800000, 32'h30000000, 29, "sticky_sat");
    checkResult("sticky_sat", 24'h800000, 1'b0, 8'd127, 1'b0, 3'b001);
    drainOutput("sticky_sat");

    applyStimulus(32'h40400000, 32'hC0400000, 3, "cancel");
    checkResult("cancel", 24'h000000, 1'b0, 8'd128, 1'b0, 3'b000);
    drainOutput("cancel");

    // -1.0 + 2.0: B is larger, result left unnormalised at exponent 128.
    applyStimulus(32'hBF800000, 32'h40000000, 4, "neg1_plus_2");
    checkResult("neg1_plus_2", 24'h400000, 1'b0, 8'd128, 1'b0, 3'b000);
    drainOutput("neg1_plus_2");

    applyStimulus(32'hC0000000, 32'h3F800000, 4, "neg2_plus_1");
    checkResult("neg2_plus_1", 24'h400000, 1'b0, 8'd128, 1'b1, 3'b000);
    drainOutput("neg2_plus_1");

    // 1.0 - 2^-24: borrow ripples through the whole mantissa.
    applyStimulus(32'h3F800000, 32'hB3800000, 27, "sub_borrow");
    checkResult("sub_borrow", 24'h7FFFFF, 1'b0, 8'd127, 1'b0, 3'b100);
    drainOutput("sub_borrow");

    applyStimulus(32'h00000001, 32'h00800000, 3, "denormal");
    checkResult("denormal", 24'h800001, 1'b0, 8'd1, 1'b0, 3'b000);
    drainOutput("denormal");

    applyStimulus(32'h7F800000, 32'h3F800000, 29, "inf_plus_one");
    checkResult("inf_plus_one", 24'h800000, 1'b0, 8'd255, 1'b0, 3'b001);
    drainOutput("inf_plus_one");

    // out_ready already high: DONE lasts exactly one cycle.
    out_ready = 1'b1;
    applyStimulus(32'h40000000, 32'h40000000, 3, "fast_return");
    checkResult("fast_return", 24'h000000, 1'b1, 8'd128, 1'b0, 3'b000);
    @(posedge clk);
    #1;
    checkOutput("fast_return in_ready", 32'(in_ready), 32'd1);
    checkOutput("fast_return out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // 1.5 + 1.0 held under backpressure while new inputs are offered.
    applyStimulus(32'h3FC00000, 32'h3F800000, 3, "backpressure");
    checkResult("backpressure", 24'h400000, 1'b1, 8'd127, 1'b0, 3'b000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      op_a     = 32'h40400000;
      op_b     = 32'h40400000;
      checkOutput("hold in_ready", 32'(in_ready), 32'd0);
      checkOutput("hold out_valid", 32'(out_valid), 32'd1);
      checkOutput("hold result", 32'(alignedResult), 32'h400000);
      checkOutput("hold exponent", 32'(exponentOut), 32'd127);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checkResult("backpressure held", 24'h400000, 1'b1, 8'd127, 1'b0, 3'b000);
    drainOutput("backpressure");
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 if (out_valid === 1'b1) seen++;
    end
    checkOutput("no queued op", 32'(seen), 32'd0);

    // Reset in the middle of a long shift.
    @(negedge clk);
    op_a     = 32'h3F800000;
    op_b     = 32'h33800000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("async reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("async reset result", 32'(alignedResult), 32'd0);
    checkOutput("async reset exponent", 32'(exponentOut), 32'd0);
    checkOutput("async reset carry", 32'(carryOut), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post reset in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1 if (out_valid === 1'b1) seen++;
    end
    checkOutput("abandoned op no output", 32'(seen), 32'd0);

    applyStimulus(32'h3F800000, 32'h3F800000, 3, "after_reset");
    checkResult("after_reset", 24'h000000, 1'b1, 8'd127, 1'b0, 3'b000);
    drainOutput("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
